// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one registered memory port between
// four requesters, with a per-transaction watchdog and per-requester completion pulses.
module mem_port_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*AW-1:0] req_addr,
    input  logic [4*DW-1:0] req_wdata,
    input  logic [3:0]      req_we,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_we,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic [3:0]      done,
    output logic [3:0]      err,
    output logic [DW-1:0]   rdata
);
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic [1:0]    ptr, win, idx;
    logic [3:0]    eff;
    logic          found, expire, start, finish;
    logic [WW-1:0] wd;

    // A requester is ignored in its own done/err cycle so a held req re-competes one cycle later.
    assign eff    = req & ~(done | err);
    assign expire = (TIMEOUT != 0) && (wd == WW'(TIMEOUT - 1));

    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eff[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        if (state == IDLE) begin
            start      = found;
            state_next = found ? BUSY : IDLE;
        end else begin
            finish     = mem_ready || expire;
            state_next = finish ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt       <= '0;
            sel       <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            ptr       <= '0;
            wd        <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            if (start) begin
                sel       <= win;
                gnt       <= 4'b0001 << win;
                mem_valid <= 1'b1;
                mem_addr  <= req_addr[win*AW +: AW];
                mem_wdata <= req_wdata[win*DW +: DW];
                mem_we    <= req_we[win];
                wd        <= '0;
            end else if (finish) begin
                gnt       <= '0;
                mem_valid <= 1'b0;
                ptr       <= sel + 2'd1;
                if (mem_ready) begin
                    done  <= gnt;
                    rdata <= mem_rdata;
                end else begin
                    err <= gnt;
                end
            end else if (state == BUSY) begin
                wd <= wd + WW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized stimulus; a transaction-level reference
// model queues expected grants/completions and a separate monitor compares them.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0, req_we = '0;
    logic [127:0] req_addr = '0, req_wdata = '0;
    logic [3:0]   gnt, done, err;
    logic [1:0]   sel;
    logic         mem_valid, mem_we;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_addr, mem_wdata, rdata;
    logic [31:0]  mem_rdata = '0;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        is_err;
    } ev_t;

    ev_t gq[$], cq[$];
    ev_t cur, mon_e, mdl_e;
    logic [31:0] rexp = '0;
    bit   mon_on = 0, prev_mv = 0, fix_rd = 0;
    int   mode = 0, ready_at = 0, nvalid = 0;
    bit   m_busy = 0;
    int   m_ptr = 0, m_id = 0, m_nv = 0;
    logic [3:0] m_mask = '0;

    mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_we(req_we), .gnt(gnt), .sel(sel), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .done(done), .err(err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Reference model: transaction view of the arbiter, one update per clock edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_busy = 0;
            m_ptr  = 0;
            m_mask = '0;
            rexp   = '0;
        end else if (m_busy) begin
            m_mask = '0;
            if (mem_ready || m_nv == TO) begin
                mdl_e.due = cyc; mdl_e.id = m_id; mdl_e.is_err = !mem_ready;
                mdl_e.a = '0; mdl_e.d = '0; mdl_e.we = 1'b0;
                cq.push_back(mdl_e);
                if (mem_ready) rexp = mem_rdata;
                m_busy = 0;
                m_ptr = (m_id + 1) % 4;
                m_mask[m_id] = 1'b1;
            end else begin
                m_nv++;
            end
        end else begin
            for (int k = 0; k < 4 && !m_busy; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (req[j] && !m_mask[j]) begin
                    m_busy = 1; m_id = j; m_nv = 1;
                    mdl_e.due = cyc; mdl_e.id = j; mdl_e.is_err = 1'b0;
                    mdl_e.a = req_addr[j*32 +: 32]; mdl_e.d = req_wdata[j*32 +: 32]; mdl_e.we = req_we[j];
                    gq.push_back(mdl_e);
                end
            end
            m_mask = '0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            bit gdue, cdue, rise, fin;
            gdue = gq.size() > 0 && gq[0].due == cyc;
            cdue = cq.size() > 0 && cq[0].due == cyc;
            rise = mem_valid && !prev_mv;
            if (rise || gdue) chk("grant_cycle", 32'(rise), 32'(gdue));
            if (gdue) begin
                cur = gq.pop_front();
                chk("sel", 32'(sel), 32'(cur.id));
                chk("gnt", 32'(gnt), 32'(1 << cur.id));
                chk("mem_addr", mem_addr, cur.a);
                chk("mem_wdata", mem_wdata, cur.d);
                chk("mem_we", 32'(mem_we), 32'(cur.we));
            end else if (mem_valid) begin
                chk("hold_sel", 32'(sel), 32'(cur.id));
                chk("hold_gnt", 32'(gnt), 32'(1 << cur.id));
                chk("hold_addr", mem_addr, cur.a);
                chk("hold_wdata", mem_wdata, cur.d);
            end else begin
                chk("gnt_idle", 32'(gnt), 32'd0);
            end
            fin = (done | err) != 4'b0;
            if (fin || cdue) chk("finish_cycle", 32'(fin), 32'(cdue));
            if (cdue) begin
                mon_e = cq.pop_front();
                chk("done", 32'(done), mon_e.is_err ? 32'd0 : 32'(1 << mon_e.id));
                chk("err", 32'(err), mon_e.is_err ? 32'(1 << mon_e.id) : 32'd0);
            end
            chk("rdata", rdata, rexp);
        end
        prev_mv = mem_valid;
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (done[i] || err[i]) req[i] = 1'b0;
        nvalid = mem_valid ? nvalid + 1 : 0;
        mem_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : mode == 2 ? (nvalid == ready_at) : ($urandom % 3 == 0);
        mem_rdata = fix_rd ? 32'hDEADBEEF : $urandom;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req = '0;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_idle(int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((req != 4'b0 || mem_valid) && n < maxc);
        chk("drain", 32'(req == 4'b0 && !mem_valid), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        pulse_reset();
        mon_on = 1;
        // single request with immediate acknowledge
        req_addr[32 +: 32] = 32'h100;
        fix_rd = 1;
        mode = 0;
        req = 4'b0010;
        run_idle(20);
        fix_rd = 0;
        // fairness from a fresh pointer, then wrap
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32] = 32'h200 + 32'(i * 16);
            req_wdata[i*32 +: 32] = $urandom;
            req_we[i] = 1'(i % 2);
        end
        req = 4'b1111;
        run_idle(40);
        req = 4'b1001;
        run_idle(20);
        // watchdog abort, then acknowledge in the last watchdog cycle
        mode = 1;
        req = 4'b0100;
        run_idle(20);
        mode = 2;
        ready_at = TO;
        req = 4'b0100;
        run_idle(20);
        // reset while busy; pointer must restart at 0
        mode = 1;
        req = 4'b0010;
        tick();
        tick();
        pulse_reset();
        mode = 0;
        req = 4'b1010;
        run_idle(20);
        // randomized traffic with held-request address churn and occasional resets
        mode = 3;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom % 4 == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*32 +: 32] = $urandom;
                    req_wdata[i*32 +: 32] = $urandom;
                    req_we[i] = 1'($urandom % 2);
                end else if (req[i] && $urandom % 8 == 0) begin
                    req_addr[i*32 +: 32] = $urandom;
                end
            end
            if (mem_valid && c > 500 && $urandom % 200 == 0) pulse_reset();
        end
        mode = 0;
        run_idle(100);
        tick();
        tick();
        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        chk("finish_queue_empty", 32'(cq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one memory port between four requesters: two fetch ports and two load/store ports. It picks one pending request, drives the 2-bit select for the shared 4:1 address/data muxes, and registers the selected request onto the memory port. It then holds the grant until the memory acknowledges or a watchdog expires, and returns the read data with a per-requester completion pulse. Select encoding matches the 4:1 mux: 00 = requester 0 through 11 = requester 3.

## Interface
Parameters:
- DW, 32, data width
- AW, 32, address width
- TIMEOUT, 15, maximum mem_valid cycles without mem_ready before abort; 0 disables the watchdog

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  4  request per requester; held high until that requester's done or err
- req_addr  in  4*AW  packed addresses; slot i = bits [i*AW +: AW]
- req_wdata  in  4*DW  packed write data; same slot packing
- req_we  in  4  write enable per requester
- gnt  out  4  one-hot grant, held for the whole transaction
- sel  out  2  index of the granted requester, drives the external 4:1 muxes
- mem_valid  out  1  memory request valid
- mem_addr  out  AW  registered address of the granted request
- mem_wdata  out  DW  registered write data of the granted request
- mem_we  out  1  registered write enable of the granted request
- mem_ready  in  1  memory acknowledge; sampled only while mem_valid = 1
- mem_rdata  in  DW  memory read data, valid with mem_ready
- done  out  4  one-cycle completion pulse for requester sel
- err  out  4  one-cycle timeout pulse for requester sel
- rdata  out  DW  read data captured at completion; holds until the next completion

## Operation
- State machine has two states, IDLE and BUSY.
- Reset (rst_n = 0 at an edge) clears every output and register:
  - gnt, sel, mem_valid, mem_addr, mem_wdata, mem_we, done, err and rdata go to 0.
  - Priority pointer goes to 0; state goes to IDLE; watchdog goes to 0.
  - Reset applied mid-transaction aborts it silently: no done, no err.
- IDLE:
  - Effective request vector = req with bit i masked while done[i] or err[i] is high.
  - Winner = first set bit of the effective vector, scanning from ptr upward with wrap 3 -> 0.
  - If the effective vector is 0, stay in IDLE.
  - On the edge after a winner exists: sel <= winner, gnt <= one-hot(winner), mem_addr/mem_wdata/mem_we <= winner's slot, mem_valid <= 1, watchdog <= 0, state <= BUSY.
- BUSY, mem_ready = 1 at an edge:
  - rdata <= mem_rdata; rdata is captured for writes too.
  - done[sel] <= 1 for one cycle.
  - gnt <= 0, mem_valid <= 0, ptr <= (sel + 1) mod 4, state <= IDLE.
- BUSY, mem_ready = 0 at an edge:
  - If TIMEOUT != 0 and watchdog == TIMEOUT-1: err[sel] <= 1 for one cycle, gnt <= 0, mem_valid <= 0, ptr <= (sel + 1) mod 4, state <= IDLE. rdata is unchanged.
  - Otherwise watchdog increments and all request outputs hold.
- Changes to req or req_* while BUSY do not affect the registered mem_* outputs.
- At most one bit of gnt, done or err is high at any time. done and err are never high in the same cycle.

## Timing
- Arbitration is a registered decision: request seen in cycle n gives mem_valid = 1 in cycle n+1.
- mem_ready high in cycle n+1 gives done and rdata in cycle n+2. Minimum latency, req to done, is 2 cycles.
- In the done/err cycle the state is already IDLE. Another pending requester is granted at the end of that cycle, so back-to-back transactions issue one every 2 cycles.
- A requester that keeps req high through its done cycle is treated as a new request one cycle later; it competes at lowest priority.
- Watchdog: with mem_ready held low, mem_valid stays high for exactly TIMEOUT cycles, then err pulses in the next cycle.
- mem_ready arriving in the final watchdog cycle completes the transaction: done, not err.

## Test plan
- Reset then single request: req = 0010, addr1 = 0x100, mem_ready high in the first mem_valid cycle, mem_rdata = 0xDEADBEEF. Expected: sel = 01, gnt = 0010, mem_addr = 0x100 one cycle after req; done = 0010 and rdata = 0xDEADBEEF the cycle after that.
- Fairness: req = 1111 held, each requester dropping its req after its done, mem_ready always 1. Expected: grant order 0, 1, 2, 3, then the next request wraps to 0; a new transaction every 2 cycles.
- Pointer wrap: after requester 3 completes, req = 1001. Expected: requester 0 is granted before requester 3.
- Timeout: TIMEOUT = 4, req = 0100, mem_ready held 0. Expected: mem_valid high for exactly 4 cycles, then err = 0100 for one cycle; done stays 0; rdata unchanged. Repeat with mem_ready = 1 in the 4th cycle. Expected: done = 0100, err = 0.
- Reset mid-transaction: rst_n = 0 while BUSY. Expected: next cycle has all outputs 0 and ptr = 0, with no done or err pulse. After release, req = 1000 is granted normally.
- Hold stability: while BUSY, change req_addr of the granted slot and toggle req of other slots. Expected: mem_addr, sel and gnt stay constant until done.
